led_scan: RTL and testbench

- Upstream multiplexing stage for the 7-segment decoder.
- Holds a 4-digit hex value and time-multiplexes it onto one shared 4-bit digit bus (`data`) feeding the decoder.
- Drives active-low digit-select lines and inserts a short blanking gap between digits to suppress ghosting.
- New values are applied only at frame boundaries, so a displayed frame is never torn.

---
 rtl/led_scan_if.sv | 21 ++
 rtl/led_scan.sv | 95 +++++++++
 tb/tb_led_scan.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/led_scan_if.sv
// Digit-scan bus between the controller side and the led_scan multiplexer.
interface led_scan_if;
    logic        en;
    logic        load;
    logic [15:0] din;
    logic [3:0]  data;
    logic [3:0]  LED_sel;
    logic        frame_tick;

    // Controller: drives enable/load/value, observes the scan outputs.
    modport master (
        output en, load, din,
        input  data, LED_sel, frame_tick
    );

    // Scanner: consumes enable/load/value, drives the decoder-facing outputs.
    modport slave (
        input  en, load, din,
        output data, LED_sel, frame_tick
    );
endinterface

// File: rtl/led_scan.sv
// Time-multiplexed 4-digit hex scanner feeding a shared 7-segment decoder.
// A shadow register takes new values at any time; they reach the displayed
// frame only at a frame boundary (or immediately while scanning is disabled).
module led_scan #(
    parameter int unsigned CLK_DIV = 50000,
    parameter int unsigned BLANK   = 4
) (
    input logic       clk,
    input logic       rst_n,
    led_scan_if.slave bus
);
    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   frame_q, frame_d;
    logic          pending_q, pending_d;
    logic          tick_q;
    logic          run_q;
    logic          boundary;
    logic          apply;

    // Slot counter and digit index; both snap to zero while disabled.
    always_comb begin
        cnt_d = '0;
        idx_d = '0;
        if (bus.en) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = '0;
                idx_d = idx_q + 2'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                idx_d = idx_q;
            end
        end
    end

    assign boundary = bus.en && (cnt_q == CNT_MAX) && (idx_q == 2'd3);
    // While disabled nothing is on screen, so a new value can land at once.
    assign apply    = boundary || !bus.en;

    // Load path: shadow always tracks the latest din; frame swaps only on apply.
    always_comb begin
        shadow_d  = shadow_q;
        frame_d   = frame_q;
        pending_d = pending_q;
        if (bus.load) begin
            shadow_d = bus.din;
        end
        if (apply) begin
            pending_d = 1'b0;
            if (bus.load) begin
                frame_d = bus.din;
            end else if (pending_q) begin
                frame_d = shadow_q;
            end
        end else if (bus.load) begin
            pending_d = 1'b1;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            frame_q   <= '0;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            frame_q   <= frame_d;
            pending_q <= pending_d;
            tick_q    <= boundary;
            run_q     <= bus.en;
        end
    end

    // Output decode from registered state only; data stays valid while blanked.
    always_comb begin
        bus.data       = frame_q[{idx_q, 2'b00} +: 4];
        bus.LED_sel    = 4'b1111;
        bus.frame_tick = tick_q;
        if (run_q && (cnt_q >= CNT_BLANK)) begin
            bus.LED_sel[idx_q] = 1'b0;
        end
    end
endmodule

// File: tb/tb_led_scan.sv
// Directed bench for led_scan with CLK_DIV=8, BLANK=2 (32-cycle frame).
module tb_led_scan;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   cyc;

    led_scan_if bus ();

    led_scan #(
        .CLK_DIV (8),
        .BLANK   (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Advance to scan cycle n, counted as rising edges since the scan (re)started.
    task automatic go(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic view(input string tag, input logic [3:0] sel, input logic [3:0] dat);
        check({tag, "_sel"}, {12'h0, bus.LED_sel}, {12'h0, sel});
        check({tag, "_dat"}, {12'h0, bus.data}, {12'h0, dat});
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        cyc      = 0;
        rst_n    = 1'b0;
        bus.en   = 1'b0;
        bus.load = 1'b0;
        bus.din  = 16'h0;
        #1;
        view("rst", 4'b1111, 4'h0);
        check("rst_tick", {15'h0, bus.frame_tick}, 16'h0);

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.en = 1'b1;
        cyc = 0;

        // Empty frame, blank/lit pattern per slot.
        view("c0", 4'b1111, 4'h0);
        go(1);  view("c1", 4'b1111, 4'h0);
        go(2);  view("c2", 4'b1110, 4'h0);
        go(7);  view("c7", 4'b1110, 4'h0);
        go(8);  view("c8", 4'b1111, 4'h0);
        go(10); view("c10", 4'b1101, 4'h0);
        go(18); view("c18", 4'b1011, 4'h0);
        go(26); view("c26", 4'b0111, 4'h0);
        go(31); check("tick31", {15'h0, bus.frame_tick}, 16'h0);
        go(32); check("tick32", {15'h0, bus.frame_tick}, 16'h1);
        view("c32", 4'b1111, 4'h0);
        go(33); check("tick33", {15'h0, bus.frame_tick}, 16'h0);

        // Mid-frame load is held until the boundary.
        go(42);
        bus.load = 1'b1; bus.din = 16'hA3C5;
        go(43);
        bus.load = 1'b0;
        view("hold43", 4'b1101, 4'h0);
        go(58); view("hold58", 4'b0111, 4'h0);
        go(63); check("tick63", {15'h0, bus.frame_tick}, 16'h0);
        go(64); check("tick64", {15'h0, bus.frame_tick}, 16'h1);
        go(66); view("a3c5_0", 4'b1110, 4'h5);

        // Two loads in one frame: only the latest shows next frame.
        go(70);
        bus.load = 1'b1; bus.din = 16'h1234;
        go(71);
        bus.load = 1'b0;
        go(74); view("a3c5_1", 4'b1101, 4'hC);
        go(80);
        bus.load = 1'b1; bus.din = 16'h5678;
        go(81);
        bus.load = 1'b0;
        go(82); view("a3c5_2", 4'b1011, 4'h3);
        go(90); view("a3c5_3", 4'b0111, 4'hA);
        go(98);  view("5678_0", 4'b1110, 4'h8);
        go(106); view("5678_1", 4'b1101, 4'h7);
        go(114); view("5678_2", 4'b1011, 4'h6);
        go(122); view("5678_3", 4'b0111, 4'h5);

        // Load in the exact boundary cycle goes straight to the display.
        go(127);
        bus.load = 1'b1; bus.din = 16'hBEEF;
        go(128);
        bus.load = 1'b0;
        check("tick128", {15'h0, bus.frame_tick}, 16'h1);
        view("beef_b", 4'b1111, 4'hF);
        go(130); view("beef_0", 4'b1110, 4'hF);
        go(138); view("beef_1", 4'b1101, 4'hE);

        // Disable mid-slot, load while disabled, then re-enable.
        go(140);
        view("pre_off", 4'b1101, 4'hE);
        bus.en = 1'b0;
        go(141);
        view("off", 4'b1111, 4'hF);
        bus.load = 1'b1; bus.din = 16'h0042;
        go(142);
        bus.load = 1'b0;
        view("off_ld", 4'b1111, 4'h2);
        go(150);
        view("off_hold", 4'b1111, 4'h2);
        check("off_tick", {15'h0, bus.frame_tick}, 16'h0);
        bus.en = 1'b1;
        cyc = 0;
        view("on0", 4'b1111, 4'h2);
        go(1);  view("on1", 4'b1111, 4'h2);
        go(2);  view("on2", 4'b1110, 4'h2);
        go(10); view("on10", 4'b1101, 4'h4);

        // Asynchronous reset at idx=2, cnt=5.
        go(21);
        view("pre_rst", 4'b1011, 4'h0);
        #2;
        rst_n = 1'b0;
        #1;
        view("arst", 4'b1111, 4'h0);
        check("arst_tick", {15'h0, bus.frame_tick}, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        view("rs0", 4'b1111, 4'h0);
        go(2);  view("rs2", 4'b1110, 4'h0);
        go(10); view("rs10", 4'b1101, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
